load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
// - Sits between the execute stage and the word-wide data RAM (sync read, 1-cycle latency, no byte enables).
// - Turns RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into RAM word accesses.
// - Sub-word stores use read-modify-write.
// - Misaligned accesses and illegal funct3 values are flagged; they never reach the RAM.
// PARAMETERS
// - DATA_WIDTH  32  RAM word width; only 32 is supported.
// - ADDR_WIDTH  10  RAM word-address width. RAM depth = 2**ADDR_WIDTH words.
// PORTS
// - CLK         in   1           single clock; all state updates on posedge.
// - RST         in   1           synchronous, active-high reset.
// - req_valid   in   1           request present.
// - req_ready   out  1           unit idle; request accepted on edge where req_valid&&req_ready.
// - req_we      in   1           1 = store, 0 = load.
// - req_funct3  in   3           RV32I funct3: 0 B, 1 H, 2 W, 4 BU, 5 HU.
// - req_addr    in   32          byte address.
// - req_wdata   in   32          store data (rs2), low bytes used for SB/SH.
// - resp_valid  out  1           one-cycle completion pulse (loads and stores).
// - resp_rdata  out  32          load result, sign/zero extended; 0 for stores or errors.
// - resp_err    out  1           valid with resp_valid: misaligned or illegal funct3.
// - mem_addr    out  ADDR_WIDTH  RAM word address = req_addr[ADDR_WIDTH+1:2]; upper bits ignored (wrap).
// - mem_read    out  1           RAM read strobe.
// - mem_write   out  1           RAM write strobe.
// - mem_wdata   out  32          RAM write data.
// - mem_rdata   in   32          RAM read data; valid the cycle after the read edge.
// BEHAVIOUR
// - Reset values:
//   - state = IDLE.
//   - req_ready = 1.
//   - resp_valid, resp_err, mem_read, mem_write = 0.
//   - resp_rdata, mem_addr, mem_wdata = 0.
// - State machine: IDLE, RD, RD_WAIT, WR, DONE.
//   - req_ready = (state==IDLE).
//   - mem_read = (state==RD).
//   - mem_write = (state==WR).
//   - resp_valid = (state==DONE).
//   - All outputs are decoded from registered state or driven from registers; no combinational path from req_* to mem_*.
// - On accept (edge N):
//   - Latch funct3, byte offset addr[1:0], we, and wdata.
//   - Load mem_addr.
// - Load (legal): IDLE -> RD -> RD_WAIT -> DONE -> IDLE.
//   - At the RD_WAIT edge, extract the lane and extend into resp_rdata.
//   - resp_valid is high in cycle N+3.
// - SW (legal): IDLE -> WR -> DONE.
//   - mem_wdata = wdata.
//   - resp_valid is high in cycle N+2.
// - SB/SH (legal): IDLE -> RD -> RD_WAIT -> WR -> DONE.
//   - At the RD_WAIT edge, mem_wdata = mem_rdata with the addressed byte/half replaced.
//   - resp_valid is high in cycle N+4.
// - Lane rules (little-endian):
//   - Byte lane = addr[1:0]*8.
//   - Half lane = addr[1]*16.
//   - B/H sign-extend; BU/HU zero-extend.
// - Error cases:
//   - H/HU/SH with addr[0]=1.
//   - W with addr[1:0]!=0.
//   - Illegal funct3: load funct3 3/6/7; store funct3 >=3.
//   - Path is IDLE -> DONE with resp_err=1 and resp_rdata=0.
//   - No mem_read/mem_write is ever asserted on this path.
// - Busy: req_valid while req_ready=0 is ignored (not queued). The requester holds it.
// - Back-to-back: a new request may be accepted on the edge after DONE (req_ready is high again in cycle after DONE).
// - Reset mid-operation: at the reset edge, state returns to IDLE and all strobes drop next cycle.
//   - An RMW reset before WR never writes.
//   - If RST is asserted in the WR cycle, the RAM still performs that write. That write is atomic and complete.
// STRUCTURE
// - Package lsu_pkg holds:
//   - funct3 localparams (F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5).
//   - typedef enum logic [2:0] lsu_state_t {IDLE, RD, RD_WAIT, WR, DONE}.
// - Sub-module lsu_align is purely combinational:
//   - load extract/extend (rdata, off, funct3) -> 32b.
//   - store merge (old, wdata, off, funct3) -> 32b.
//   - Unit-testable alone.
// - Top level holds the FSM and registers only.
// TESTING (bench instantiates load_store_unit + RAM, ADDR_WIDTH=10)
// - Case 1: SW addr 0x10 data 0xDEADBEEF, then LW 0x10.
//   - Store: resp_valid at N+2, err=0.
//   - Load: resp_rdata=0xDEADBEEF at N+3.
// - Case 2: after case 1, LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD.
// - Case 3: after case 1, SB 0x11 data 0x00000055 then LW 0x10 -> 0xDEAD55EF.
//   - Exactly one mem_read then one mem_write.
//   - resp_valid at N+4.
// - Case 4: SW 0x12 -> resp_err=1 at N+1, mem_write never high, word 0x10 unchanged. LH 0x11 -> resp_err=1, resp_rdata=0.
// - Case 5: SH 0x1002 data 0x1234 (addr wraps to word 0) then LW 0x0 -> 0x12340000.
//   - req_valid pulses during busy are dropped (no extra mem strobes).
// - Case 6: RST asserted during RD_WAIT of SB 0x20 -> no write; word 0x20 is unchanged; req_ready=1 next cycle.
//   - Outputs at reset values.
// - Assertions:
//   - mem_read && mem_write never both high.
//   - resp_valid is exactly one cycle per accepted request.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, FSM state type and access legality check
// Contents:
//   F3_*          RV32I load/store funct3 encodings
//   lsu_state_t   load/store unit FSM states
//   access_err()  1 when a request is misaligned or uses an illegal funct3
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, DONE} lsu_state_t;

  // Stores only have B/H/W; loads additionally have BU/HU.
  function automatic logic access_err(input logic we, input logic [2:0] f3, input logic [1:0] off);
    logic illegal;
    logic misaligned;
    if (we) illegal = (f3 != F3_B) && (f3 != F3_H) && (f3 != F3_W);
    else    illegal = !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    misaligned = (((f3 == F3_H) || (f3 == F3_HU)) && off[0]) ||
                 ((f3 == F3_W) && (off != 2'b00));
    return illegal || misaligned;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request/response and data-RAM bus of the load/store unit
// Signals:
//   req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata   execute-stage request
//   resp_valid/resp_rdata/resp_err                             completion pulse and load result
//   mem_addr/mem_read/mem_write/mem_wdata/mem_rdata            word-wide sync-read data RAM
// Modports: slave = the load/store unit, master = execute stage plus RAM.
interface load_store_unit_if #(parameter int ADDR_WIDTH = 10);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [31:0]           req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic                  resp_err;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_read;
  logic                  mem_write;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_read, mem_write, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_read, mem_write, mem_wdata
  );

endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational lane extract/extend for loads and byte/half merge for stores
// Ports:
//   word        in   32  RAM word just read
//   wdata       in   32  store data, low byte/half used for SB/SH
//   off         in   2   byte offset within the word
//   funct3      in   3   access size and signedness
//   load_data   out  32  addressed lane, sign- or zero-extended
//   store_data  out  32  word with the addressed byte/half replaced
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Little-endian: byte lane at off*8, half lane at off[1]*16.
  assign byte_lane = word[{off, 3'b000} +: 8];
  assign half_lane = word[{off[1], 4'b0000} +: 16];

  always_comb begin
    load_data = word;
    unique case (funct3)
      F3_B:    load_data = {{24{byte_lane[7]}}, byte_lane};
      F3_BU:   load_data = {24'd0, byte_lane};
      F3_H:    load_data = {{16{half_lane[15]}}, half_lane};
      F3_HU:   load_data = {16'd0, half_lane};
      default: load_data = word;
    endcase
  end

  always_comb begin
    store_data = word;
    unique case (funct3[1:0])
      2'd0:    store_data[{off, 3'b000} +: 8]     = wdata[7:0];
      2'd1:    store_data[{off[1], 4'b0000} +: 16] = wdata[15:0];
      default: store_data = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit in front of a word-wide sync-read data RAM
// Ports:
//   CLK   in  1  clock, all state on posedge
//   RST   in  1  synchronous active-high reset
//   bus   slave modport of load_store_unit_if (request, response and RAM signals)
// Sub-word stores are read-modify-write; errored requests go straight to DONE
// without touching the RAM.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input logic                  CLK,
  input logic                  RST,
  load_store_unit_if.slave     bus
);

  lsu_state_t            state_q, state_d;
  logic [2:0]            f3_q;
  logic [1:0]            off_q;
  logic                  we_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  req_err;
  logic [31:0]           load_data;
  logic [31:0]           store_data;

  assign req_err = access_err(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);

  // mem_wdata_q holds the raw store data until the merge replaces it, so the
  // aligner takes its wdata from there.
  lsu_align u_align (
    .word       (bus.mem_rdata),
    .wdata      (mem_wdata_q),
    .off        (off_q),
    .funct3     (f3_q),
    .load_data  (load_data),
    .store_data (store_data)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (req_err)                    state_d = DONE;
          else if (!bus.req_we)           state_d = RD;
          else if (bus.req_funct3 == F3_W) state_d = WR;
          else                            state_d = RD;
        end
      end
      RD:      state_d = RD_WAIT;
      RD_WAIT: state_d = we_q ? WR : DONE;
      WR:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      f3_q        <= '0;
      off_q       <= '0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.req_valid) begin
        f3_q        <= bus.req_funct3;
        off_q       <= bus.req_addr[1:0];
        we_q        <= bus.req_we;
        err_q       <= req_err;
        mem_addr_q  <= bus.req_addr[ADDR_WIDTH+1:2];
        mem_wdata_q <= bus.req_wdata;
        rdata_q     <= '0;
      end else if (state_q == RD_WAIT) begin
        if (we_q) mem_wdata_q <= store_data;
        else      rdata_q     <= load_data;
      end
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.mem_read   = (state_q == RD);
  assign bus.mem_write  = (state_q == WR);
  assign bus.resp_valid = (state_q == DONE);
  assign bus.resp_err   = (state_q == DONE) && err_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench for load_store_unit with a byte-array reference
module tb_load_store_unit;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  load_store_unit_if #(.ADDR_WIDTH(10)) bus ();

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // Data RAM: sync read, one-cycle latency.
  logic [31:0] ram [0:1023];
  always @(posedge CLK) begin
    if (bus.mem_write) ram[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_read)  bus.mem_rdata <= ram[bus.mem_addr];
  end

  // Reference memory as bytes; 4 KiB window because the word address wraps at 10 bits.
  logic [7:0] ref_bytes [0:4095];

  int n_tests = 0;
  int n_fail  = 0;
  int both_cnt = 0;
  int resp_cnt = 0;
  int accept_cnt = 0;

  always @(negedge CLK) begin
    if (bus.mem_read && bus.mem_write) both_cnt++;
    if (bus.resp_valid) resp_cnt++;
  end

  always @(posedge CLK) begin
    if (!RST && bus.req_valid && bus.req_ready) accept_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic ref_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    int size;
    logic illegal;
    size = int'(f3 & 3'd3);
    if (we) illegal = (f3 > 3'd2);
    else    illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    return illegal || (size == 1 && addr[0]) || (size == 2 && addr[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
    int b;
    int n;
    logic [31:0] val;
    logic [31:0] mask;
    b = int'(addr & 32'hFFF);
    n = 1 << int'(f3 & 3'd3);
    val = 0;
    for (int i = 0; i < n; i++) val = val | (32'(ref_bytes[b + i]) << (8 * i));
    if (!f3[2] && n < 4) begin
      mask = (32'd1 << (8 * n)) - 32'd1;
      if (val[8 * n - 1]) val = val | ~mask;
    end
    return val;
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
    int b;
    int n;
    b = int'(addr & 32'hFFF);
    n = 1 << int'(f3 & 3'd3);
    for (int i = 0; i < n; i++) ref_bytes[b + i] = 8'(wdata >> (8 * i));
  endtask

  // Issue one request; report latency in cycles after the accept edge,
  // strobe counts and the width of the resp_valid pulse.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit noise,
                        output logic [31:0] rdata, output logic err,
                        output int lat, output int reads, output int writes, output int width);
    int guard;
    @(negedge CLK);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    guard = 0;
    while (!bus.req_ready && guard < 20) begin
      @(negedge CLK);
      guard++;
    end
    @(posedge CLK);
    #1;
    bus.req_valid = 1'b0;
    lat = 0; reads = 0; writes = 0; width = 0;
    rdata = 32'hx; err = 1'bx;
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLK);
      if (noise) begin
        bus.req_valid  = 1'($urandom_range(0, 1));
        bus.req_we     = 1'($urandom_range(0, 1));
        bus.req_funct3 = 3'($urandom_range(0, 7));
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
      end
      reads  += int'(bus.mem_read);
      writes += int'(bus.mem_write);
      if (bus.resp_valid) begin
        lat   = k;
        rdata = bus.resp_rdata;
        err   = bus.resp_err;
        bus.req_valid = 1'b0;
        break;
      end
    end
    bus.req_valid = 1'b0;
    @(negedge CLK);
    if (lat != 0) width = bus.resp_valid ? 2 : 1;
  endtask

  task automatic run(input string tag, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata, input bit noise,
                     output logic [31:0] rdata_o);
    logic exp_err;
    int exp_lat, exp_reads, exp_writes;
    logic [31:0] exp_rdata;
    logic [31:0] rdata;
    logic err;
    int lat, reads, writes, width;
    exp_err    = ref_err(we, f3, addr);
    exp_lat    = exp_err ? 1 : (!we ? 3 : (f3 == 3'd2 ? 2 : 4));
    exp_reads  = (exp_err || (we && f3 == 3'd2)) ? 0 : 1;
    exp_writes = (!exp_err && we) ? 1 : 0;
    exp_rdata  = (exp_err || we) ? 32'd0 : ref_load(f3, addr);
    do_req(we, f3, addr, wdata, noise, rdata, err, lat, reads, writes, width);
    check({tag, "/lat"},    32'(lat),    32'(exp_lat));
    check({tag, "/err"},    32'(err),    32'(exp_err));
    check({tag, "/rdata"},  rdata,       exp_rdata);
    check({tag, "/reads"},  32'(reads),  32'(exp_reads));
    check({tag, "/writes"}, 32'(writes), 32'(exp_writes));
    check({tag, "/width"},  32'(width),  32'd1);
    if (!exp_err && we) ref_store(f3, addr, wdata);
    rdata_o = rdata;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    int aborted;
    aborted = 0;
    for (int i = 0; i < 1024; i++) ram[i] = 32'd0;
    for (int i = 0; i < 4096; i++) ref_bytes[i] = 8'd0;
    RST = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst/ready",      32'(bus.req_ready),  32'd1);
    check("rst/resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst/resp_err",   32'(bus.resp_err),   32'd0);
    check("rst/mem_read",   32'(bus.mem_read),   32'd0);
    check("rst/mem_write",  32'(bus.mem_write),  32'd0);
    check("rst/resp_rdata", bus.resp_rdata,      32'd0);
    check("rst/mem_addr",   32'(bus.mem_addr),   32'd0);
    check("rst/mem_wdata",  bus.mem_wdata,       32'd0);
    RST = 1'b0;

    // Case 1
    run("c1_sw", 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0, r);
    run("c1_lw", 1'b0, 3'd2, 32'h10, 32'h0, 1'b0, r);
    check("c1_lw_const", r, 32'hDEADBEEF);
    // Case 2
    run("c2_lb",  1'b0, 3'd0, 32'h13, 32'h0, 1'b0, r);
    check("c2_lb_const", r, 32'hFFFFFFDE);
    run("c2_lbu", 1'b0, 3'd4, 32'h13, 32'h0, 1'b0, r);
    check("c2_lbu_const", r, 32'h000000DE);
    run("c2_lh",  1'b0, 3'd1, 32'h10, 32'h0, 1'b0, r);
    check("c2_lh_const", r, 32'hFFFFBEEF);
    run("c2_lhu", 1'b0, 3'd5, 32'h12, 32'h0, 1'b0, r);
    check("c2_lhu_const", r, 32'h0000DEAD);
    // Case 3
    run("c3_sb", 1'b1, 3'd0, 32'h11, 32'h00000055, 1'b0, r);
    run("c3_lw", 1'b0, 3'd2, 32'h10, 32'h0, 1'b0, r);
    check("c3_lw_const", r, 32'hDEAD55EF);
    // Case 4
    run("c4_sw_mis", 1'b1, 3'd2, 32'h12, 32'h11111111, 1'b0, r);
    run("c4_lw",     1'b0, 3'd2, 32'h10, 32'h0, 1'b0, r);
    check("c4_lw_const", r, 32'hDEAD55EF);
    run("c4_lh_mis", 1'b0, 3'd1, 32'h11, 32'h0, 1'b0, r);
    // Case 5
    run("c5_sh_wrap", 1'b1, 3'd1, 32'h1002, 32'h00001234, 1'b1, r);
    run("c5_lw",      1'b0, 3'd2, 32'h0, 32'h0, 1'b1, r);
    check("c5_lw_const", r, 32'h12340000);

    // Case 6: reset during RD_WAIT of an SB must not write
    run("c6_sw", 1'b1, 3'd2, 32'h20, 32'hCAFEF00D, 1'b0, r);
    @(negedge CLK);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'h21;
    bus.req_wdata  = 32'h000000AB;
    @(posedge CLK);
    #1;
    bus.req_valid = 1'b0;
    aborted = 1;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    check("c6/ready",      32'(bus.req_ready),  32'd1);
    check("c6/resp_valid", 32'(bus.resp_valid), 32'd0);
    check("c6/resp_err",   32'(bus.resp_err),   32'd0);
    check("c6/mem_read",   32'(bus.mem_read),   32'd0);
    check("c6/mem_write",  32'(bus.mem_write),  32'd0);
    check("c6/resp_rdata", bus.resp_rdata,      32'd0);
    check("c6/mem_addr",   32'(bus.mem_addr),   32'd0);
    check("c6/mem_wdata",  bus.mem_wdata,       32'd0);
    run("c6_lw", 1'b0, 3'd2, 32'h20, 32'h0, 1'b0, r);
    check("c6_lw_const", r, 32'hCAFEF00D);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 1) ? 32'h1000 * $urandom_range(0, 15) : 32'd0) + 32'($urandom_range(0, 63));
      run("rnd", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
          1'($urandom_range(0, 1)), r);
    end

    check("both_strobes", 32'(both_cnt), 32'd0);
    check("resp_per_accept", 32'(resp_cnt), 32'(accept_cnt - aborted));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
